pll_ce_supervisor: RTL and testbench
====================================

# pll_ce_supervisor

Parametrised successor to the single-output PLL divider stage. It supervises an external PLL `locked` flag, qualifies it with a synchroniser, a lock timeout and a settle window, and only then runs N independent clock-enable dividers. The dividers use runtime-programmable ratios and produce single-cycle `ce` pulses plus a square-wave companion per channel. A status LED and lock-loss counter are included. Everything runs on the 100 MHz input clock; the block sits between the PLL IP and the logic that consumes the derived rates.

## Interface
- `N_CH`, 2: number of divider channels (1..8).
- `CNT_W`, 16: width of each divide ratio and channel counter.
- `SYNC_STAGES`, 2: flops in the `locked_i` synchroniser (≥2).
- `SETTLE_CYC`, 16: consecutive synchronised-lock cycles required before RUN (≥1).
- `LOCK_TIMEOUT`, 20000: cycles allowed in WAIT_LOCK before declaring fault (200 µs at 100 MHz).
- `LED_DIV`, 50_000_000: cycles per LED toggle in RUN; must be divisible by 8.

Ports:
- `clk100`  in  1  sole clock, 100 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `locked_i`  in  1  PLL lock flag, asynchronous to `clk100`.
- `div_i`  in  N_CH*CNT_W  divide ratio; channel k is bits [k*CNT_W +: CNT_W].
- `ce_o`  out  N_CH  one-cycle clock-enable pulse per channel.
- `sq_o`  out  N_CH  square wave at the divided rate.
- `running_o`  out  1  high while in RUN.
- `fault_o`  out  1  sticky lock-timeout flag.
- `relock_cnt_o`  out  8  saturating count of lock losses while in RUN.
- `led`  out  1  status LED.

## Operation
- `locked_i` passes through SYNC_STAGES flops to give `lock_s`. The FSM acts only on `lock_s`.
- FSM states: WAIT_LOCK (reset state), SETTLE, RUN, FAULT.
  - WAIT_LOCK: the timeout counter increments each cycle.
    - `lock_s`=1 → SETTLE, and the timeout counter clears.
    - If the counter reaches LOCK_TIMEOUT-1 with `lock_s`=0 → FAULT, and `fault_o` is set.
  - SETTLE: the settle counter increments while `lock_s`=1.
    - `lock_s`=0 → WAIT_LOCK; the settle and timeout counters restart from 0.
    - Settle counter = SETTLE_CYC-1 → RUN.
  - RUN: the dividers are active.
    - `lock_s`=0 → WAIT_LOCK; `relock_cnt_o` increments, saturating at 255; all channel counters clear.
  - FAULT: `lock_s`=1 → SETTLE. `fault_o` stays 1 until `rst`.
- Divider channel k:
  - `div_i[k]` is latched on the cycle the FSM enters RUN. Changes to `div_i` during RUN are ignored.
  - A latched value of 0 is treated as 1.
  - The counter runs 0..div-1 and wraps to 0; the first RUN cycle has count=0.
  - `ce_o[k]` = RUN && count==div-1.
  - `sq_o[k]` = RUN && count < (div>>1).
  - For div=1: `ce_o` is high every RUN cycle and `sq_o` is 0.
- LED:
  - 0 in WAIT_LOCK and SETTLE.
  - In RUN, toggles every LED_DIV cycles, starting low at RUN entry.
  - In FAULT, toggles every LED_DIV/8 cycles.
  - The LED counter clears on every state change.
- `ce_o`, `sq_o`, `running_o` and `led` are decoded only from registers, with no combinational path from the inputs.
- Reset values: all outputs 0, state WAIT_LOCK, all counters and synchroniser flops 0. Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.

## Timing
- `locked_i` rising, captured at edge E: `lock_s`=1 after edge E+SYNC_STAGES-1; state = SETTLE after edge E+SYNC_STAGES; `running_o`=1 after edge E+SYNC_STAGES+SETTLE_CYC. With defaults, this is 18 cycles.
- `locked_i` falling in RUN: `running_o`, `ce_o` and `sq_o` all go 0 after edge E+SYNC_STAGES. No `ce_o` pulse is emitted after `running_o` falls.
- First `ce_o[k]` is in RUN cycle index div-1, counting the first RUN cycle as index 0. After that, the period is exactly div cycles.
- `fault_o` rises exactly LOCK_TIMEOUT cycles after `rst` deasserts, provided `lock_s` never rose.
- Simultaneous events resolve as follows:
  - `lock_s` rising on the timeout-terminal cycle → SETTLE, and no fault is raised.
  - `lock_s` falling on the last SETTLE cycle → WAIT_LOCK.

## Test plan
- Reset, `div_i`={ch1=3, ch0=10}, `locked_i`↑ 5 cycles after reset release → `running_o` 18 cycles later. `ce0` every 10 cycles, first at RUN index 9, with `sq0` 5 high / 5 low. `ce1` every 3 cycles, with `sq1` 1 high / 2 low. Exactly 10 `clk100` edges per `ce0` period.
- LOCK_TIMEOUT=1000, `locked_i` held 0 → `fault_o`=1 at cycle 1000 and `led` toggles every LED_DIV/8 cycles. Then `locked_i`=1 → RUN after 18 cycles, with `fault_o` still 1.
- `locked_i` drops for 3 cycles at settle count 8 → back to WAIT_LOCK. `running_o` rises only after a fresh 16-cycle settle, and `relock_cnt_o` stays 0.
- Lock loss in RUN → `relock_cnt_o`=1 and `ce_o` silent within SYNC_STAGES+1 cycles. On re-lock, the first `ce0` is again at RUN index 9. 300 loss cycles → `relock_cnt_o`=255.
- `div_i` changes 0→7 mid-RUN → no effect until the next RUN entry. Latched `div`=0 or 1 → `ce_o` high every cycle and `sq_o`=0.
- `rst` pulsed asynchronously mid-RUN, between clock edges → all outputs 0 before the next edge, and the FSM restarts in WAIT_LOCK.

Source files
------------

// File: rtl/pll_ce_supervisor.sv
// pll_ce_supervisor: qualifies an async PLL lock flag, then runs N programmable clock-enable dividers.
module pll_ce_supervisor #(
  parameter int N_CH = 2,
  parameter int CNT_W = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC = 16,
  parameter int LOCK_TIMEOUT = 20000,
  parameter int LED_DIV = 50_000_000
) (
  input  logic                    clk100,
  input  logic                    rst,
  input  logic                    locked_i,
  input  logic [N_CH*CNT_W-1:0]   div_i,
  output logic [N_CH-1:0]         ce_o,
  output logic [N_CH-1:0]         sq_o,
  output logic                    running_o,
  output logic                    fault_o,
  output logic [7:0]              relock_cnt_o,
  output logic                    led
);
  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN, FAULT} state_t;
  localparam int TW = LOCK_TIMEOUT > 1 ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  state_t state, next;
  logic [SYNC_STAGES-1:0] sync;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] set_cnt;
  logic [31:0] led_cnt;
  logic lock_s, stay, enter_run, led_wrap;
  assign lock_s = sync[SYNC_STAGES-1];
  assign stay = next == state;
  assign enter_run = next == RUN && state != RUN;
  assign running_o = state == RUN;
  assign led_wrap = led_cnt == ((state == FAULT) ? 32'(LED_DIV / 8 - 1) : 32'(LED_DIV - 1));
  // A rising lock_s wins over the timeout terminal count
  always_comb begin
    next = state;
    case (state)
      WAIT_LOCK: next = lock_s ? SETTLE : (tmo_cnt == TW'(LOCK_TIMEOUT - 1)) ? FAULT : WAIT_LOCK;
      SETTLE:    next = !lock_s ? WAIT_LOCK : (set_cnt == SW'(SETTLE_CYC - 1)) ? RUN : SETTLE;
      RUN:       next = lock_s ? RUN : WAIT_LOCK;
      default:   next = lock_s ? SETTLE : FAULT;
    endcase
  end
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      sync <= '0;
      state <= WAIT_LOCK;
      tmo_cnt <= '0;
      set_cnt <= '0;
      led_cnt <= '0;
      led <= 1'b0;
      fault_o <= 1'b0;
      relock_cnt_o <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], locked_i};
      state <= next;
      tmo_cnt <= (state == WAIT_LOCK && stay) ? tmo_cnt + TW'(1) : '0;
      set_cnt <= (state == SETTLE && stay) ? set_cnt + SW'(1) : '0;
      led_cnt <= (!stay || led_wrap) ? '0 : led_cnt + 32'd1;
      led <= stay && (state == RUN || state == FAULT) && (led ^ led_wrap);
      fault_o <= fault_o | (next == FAULT);
      relock_cnt_o <= relock_cnt_o + 8'(state == RUN && !lock_s && relock_cnt_o != 8'hFF);
    end
  end
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [CNT_W-1:0] d, div_q, cnt;
    assign d = div_i[k*CNT_W +: CNT_W];
    always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
        div_q <= '0;
        cnt <= '0;
      end else begin
        if (enter_run) div_q <= (d == '0) ? CNT_W'(1) : d;
        cnt <= (state == RUN && stay && cnt != div_q - CNT_W'(1)) ? cnt + CNT_W'(1) : '0;
      end
    end
    assign ce_o[k] = state == RUN && cnt == div_q - CNT_W'(1);
    assign sq_o[k] = state == RUN && cnt < (div_q >> 1);
  end
endmodule

// File: tb/tb_pll_ce_supervisor.sv
// tb_pll_ce_supervisor: scenario tasks plus a scoreboard of expected ce/sq per RUN cycle.
module tb_pll_ce_supervisor;
  localparam int LT = 1000;
  localparam int LD = 80;
  logic clk100 = 1'b0, rst = 1'b1, locked_i = 1'b0;
  logic [31:0] div_i = '0;
  logic [1:0] ce_o, sq_o;
  logic running_o, fault_o, led;
  logic [7:0] relock_cnt_o;
  logic [3:0] sb[$];
  logic [3:0] exp_v;
  int errors = 0, checks = 0;

  pll_ce_supervisor #(.N_CH(2), .CNT_W(16), .SYNC_STAGES(2), .SETTLE_CYC(16),
                      .LOCK_TIMEOUT(LT), .LED_DIV(LD)) dut (
    .clk100(clk100), .rst(rst), .locked_i(locked_i), .div_i(div_i), .ce_o(ce_o), .sq_o(sq_o),
    .running_o(running_o), .fault_o(fault_o), .relock_cnt_o(relock_cnt_o), .led(led));

  always #5 clk100 = ~clk100;

  always @(negedge clk100) begin
    if (!rst && running_o && sb.size() > 0) begin
      exp_v = sb.pop_front();
      checks++;
      if ({ce_o, sq_o} !== exp_v) begin errors++; $display("FAIL sb_run: got ce,sq=%b required %b", {ce_o, sq_o}, exp_v); end
    end else if (!rst && !running_o) begin
      checks++;
      if ({ce_o, sq_o} !== 4'b0) begin errors++; $display("FAIL idle_quiet: got ce,sq=%b required 0000", {ce_o, sq_o}); end
    end
  end

  task automatic push_run(input int d0, input int d1, input int n);
    int a, b;
    logic c0, c1, s0, s1;
    a = d0 == 0 ? 1 : d0;
    b = d1 == 0 ? 1 : d1;
    for (int i = 0; i < n; i++) begin
      c0 = (i % a) == a - 1; c1 = (i % b) == b - 1;
      s0 = (i % a) < a / 2;  s1 = (i % b) < b / 2;
      sb.push_back({c1, c0, s1, s0});
    end
  endtask

  task automatic wait_run(input logic v, output int lat);
    lat = 0;
    @(negedge clk100);
    while (running_o !== v && lat < 200) begin @(negedge clk100); lat++; end
  endtask

  task automatic apply_reset();
    rst = 1'b1; locked_i = 1'b0; sb.delete();
    repeat (3) @(negedge clk100);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked_i = 1'b0; div_i = '0;
    repeat (3) @(negedge clk100);
    checks++; if (running_o !== 1'b0) begin errors++; $display("FAIL rst_running: got %b required 0", running_o); end
    checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b required 0", fault_o); end
    checks++; if ({ce_o, sq_o} !== 4'b0) begin errors++; $display("FAIL rst_ce_sq: got %b required 0000", {ce_o, sq_o}); end
    checks++; if (relock_cnt_o !== 8'd0) begin errors++; $display("FAIL rst_relock: got %0d required 0", relock_cnt_o); end
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL rst_led: got %b required 0", led); end
    rst = 1'b0;
  endtask

  task automatic test_settle_glitch();
    int lat;
    apply_reset();
    div_i = {16'd3, 16'd10};
    locked_i = 1'b1;
    repeat (10) @(negedge clk100);
    checks++; if (running_o !== 1'b0) begin errors++; $display("FAIL glitch_early_run: got %b required 0", running_o); end
    locked_i = 1'b0;
    repeat (3) @(negedge clk100);
    locked_i = 1'b1;
    wait_run(1'b1, lat);
    checks++; if (lat !== 18) begin errors++; $display("FAIL glitch_resettle_latency: got %0d required 18", lat); end
    checks++; if (relock_cnt_o !== 8'd0) begin errors++; $display("FAIL glitch_relock: got %0d required 0", relock_cnt_o); end
  endtask

  task automatic test_lock_run();
    int lat, first, second;
    apply_reset();
    repeat (5) @(negedge clk100);
    div_i = {16'd3, 16'd10};
    push_run(10, 3, 60);
    locked_i = 1'b1;
    wait_run(1'b1, lat);
    checks++; if (lat !== 18) begin errors++; $display("FAIL run_latency: got %0d required 18", lat); end
    first = -1; second = -1;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk100);
      if (i == 20) div_i = {16'd7, 16'd7};
      if (ce_o[0] === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    #1;
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL run_sb_drained: got %0d left required 0", sb.size()); end
    checks++; if (first !== 9) begin errors++; $display("FAIL run_first_ce0: got %0d required 9", first); end
    checks++; if (second - first !== 10) begin errors++; $display("FAIL run_ce0_period: got %0d required 10", second - first); end
    checks++; if ({fault_o, led} !== 2'b00) begin errors++; $display("FAIL run_fault_led: got %b required 00", {fault_o, led}); end
  endtask

  task automatic test_div01();
    int lat, first;
    apply_reset();
    div_i = {16'd1, 16'd0};
    push_run(0, 1, 20);
    locked_i = 1'b1;
    wait_run(1'b1, lat);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk100);
      if (i == 5) div_i = {16'd7, 16'd7};
    end
    checks++; if ({ce_o, sq_o} !== 4'b1100) begin errors++; $display("FAIL div01_ce_sq: got %b required 1100", {ce_o, sq_o}); end
    locked_i = 1'b0;
    wait_run(1'b0, lat);
    sb.delete();
    push_run(7, 7, 21);
    locked_i = 1'b1;
    wait_run(1'b1, lat);
    first = -1;
    for (int i = 0; i < 21; i++) begin
      if (i > 0) @(negedge clk100);
      if (ce_o[0] === 1'b1 && first < 0) first = i;
    end
    #1;
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL div7_sb_drained: got %0d left required 0", sb.size()); end
    checks++; if (first !== 6) begin errors++; $display("FAIL div7_first_ce0: got %0d required 6", first); end
  endtask

  task automatic test_fault();
    int lat, first, n;
    logic prev;
    apply_reset();
    lat = 0;
    while (fault_o !== 1'b1 && lat < 2000) begin @(negedge clk100); lat++; end
    checks++; if (lat !== LT) begin errors++; $display("FAIL fault_latency: got %0d required %0d", lat, LT); end
    checks++; if ({running_o, led} !== 2'b00) begin errors++; $display("FAIL fault_entry_outputs: got %b required 00", {running_o, led}); end
    first = -1; n = 0; prev = led;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk100);
      if (led !== prev) begin n++; if (first < 0) first = i; prev = led; end
    end
    checks++; if (first !== LD / 8) begin errors++; $display("FAIL fault_led_first: got %0d required %0d", first, LD / 8); end
    checks++; if (n !== 4) begin errors++; $display("FAIL fault_led_toggles: got %0d required 4", n); end
    locked_i = 1'b1;
    wait_run(1'b1, lat);
    checks++; if (lat !== 18) begin errors++; $display("FAIL fault_relock_latency: got %0d required 18", lat); end
    checks++; if (fault_o !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b required 1", fault_o); end
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL fault_run_led: got %b required 0", led); end
  endtask

  task automatic test_timeout_race();
    int lat;
    apply_reset();
    repeat (LT - 3) @(negedge clk100);
    locked_i = 1'b1;
    wait_run(1'b1, lat);
    checks++; if (lat !== 18) begin errors++; $display("FAIL race_latency: got %0d required 18", lat); end
    checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL race_fault: got %b required 0", fault_o); end
  endtask

  task automatic test_lock_loss();
    int lat, first, bad, noisy;
    apply_reset();
    div_i = {16'd3, 16'd10};
    push_run(10, 3, 25);
    locked_i = 1'b1;
    wait_run(1'b1, lat);
    repeat (24) @(negedge clk100);
    locked_i = 1'b0;
    wait_run(1'b0, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL loss_latency: got %0d required 2", lat); end
    checks++; if (relock_cnt_o !== 8'd1) begin errors++; $display("FAIL loss_relock: got %0d required 1", relock_cnt_o); end
    noisy = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk100); if (ce_o !== 2'b00) noisy++; end
    checks++; if (noisy !== 0) begin errors++; $display("FAIL loss_ce_silent: got %0d pulses required 0", noisy); end
    sb.delete();
    push_run(10, 3, 30);
    locked_i = 1'b1;
    wait_run(1'b1, lat);
    first = -1;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk100);
      if (ce_o[0] === 1'b1 && first < 0) first = i;
    end
    checks++; if (first !== 9) begin errors++; $display("FAIL relock_first_ce0: got %0d required 9", first); end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      locked_i = 1'b0; wait_run(1'b0, lat); if (lat >= 200) bad++;
      locked_i = 1'b1; wait_run(1'b1, lat); if (lat >= 200) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL loss_loop_timeouts: got %0d required 0", bad); end
    checks++; if (relock_cnt_o !== 8'd255) begin errors++; $display("FAIL relock_saturate: got %0d required 255", relock_cnt_o); end
  endtask

  task automatic test_async_reset();
    int lat;
    @(posedge clk100);
    #3 rst = 1'b1;
    #1;
    checks++; if ({running_o, fault_o, led, ce_o, sq_o} !== 7'b0) begin errors++; $display("FAIL async_outputs: got %b required 0000000", {running_o, fault_o, led, ce_o, sq_o}); end
    checks++; if (relock_cnt_o !== 8'd0) begin errors++; $display("FAIL async_relock: got %0d required 0", relock_cnt_o); end
    repeat (2) @(negedge clk100);
    rst = 1'b0;
    wait_run(1'b1, lat);
    checks++; if (lat !== 18) begin errors++; $display("FAIL async_restart_latency: got %0d required 18", lat); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_settle_glitch();
    test_lock_run();
    test_div01();
    test_fault();
    test_timeout_race();
    test_lock_loss();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
